jk_mod_counter: RTL

Synchronous modulo-N up/down counter whose state bits are JK storage cells. The block computes the J/K excitation for each bit from the current count and the control inputs. It is the excitation stage that sits directly upstream of the JK flip-flops, packaged together with them. It serves as a reusable counting element (BCD digit, timer prescaler) for later labs, and exposes its J/K vectors so benches can check excitation directly.

---
 rtl/jk_pkg.sv | 14 +
 rtl/jk_cell.sv | 26 ++
 rtl/jk_mod_counter.sv | 81 ++++++++
 3 files changed

// File: rtl/jk_pkg.sv
// Shared JK definitions: {J,K} operation encodings and default counter geometry.
package jk_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_MODULUS = 10;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_RST  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_op_e;

endpackage

// File: rtl/jk_cell.sv
// One-bit JK storage element with synchronous active-high reset.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic J,
    input  logic K,
    output logic Q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            Q <= 1'b0;
        end else begin
            case (jk_op_e'({J, K}))
                JK_HOLD: Q <= Q;
                JK_RST:  Q <= 1'b0;
                JK_SET:  Q <= 1'b1;
                JK_TOG:  Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter built from JK cells; exposes its J/K excitation vectors.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned MODULUS = DEF_MODULUS
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             load_err,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k
);

    // One extra bit so MODULUS == 2^WIDTH is representable in comparisons.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] n;
    logic             d_ok;
    logic             q_ok;
    logic             err_n;

    // Next-state selection: reset, then load, then count, then hold.
    always_comb begin
        d_ok  = ({1'b0, d} < MOD_EXT);
        q_ok  = ({1'b0, Q} < MOD_EXT);
        n     = Q;
        err_n = 1'b0;
        if (reset) begin
            n = '0;
        end else if (load) begin
            if (d_ok) begin
                n = d;
            end else begin
                n     = '0;
                err_n = 1'b1;
            end
        end else if (en) begin
            if (!q_ok) begin
                n = '0;
            end else if (up) begin
                n = (Q == TOP) ? '0 : Q + WIDTH'(1);
            end else begin
                n = (Q == '0) ? TOP : Q - WIDTH'(1);
            end
        end
    end

    assign jk_j = ~Q & n;
    assign jk_k = Q & ~n;

    assign tc = ~reset & en & ~load & ((up & (Q == TOP)) | (~up & (Q == '0)));

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .J     (jk_j[i]),
            .K     (jk_k[i]),
            .Q     (Q[i])
        );
    end

    // The error flag is stored in a JK cell as well, driven with minimal excitation.
    jk_cell u_err (
        .clk   (clk),
        .reset (reset),
        .J     (err_n & ~load_err),
        .K     (~err_n & load_err),
        .Q     (load_err)
    );

endmodule
